// File: rtl/fifo_rd_stream.sv
// -----------------------------------------------------------------------------
// fifo_rd_stream
//
// Read-side drain engine for the async FIFO, living entirely in the FIFO read
// clock domain. It issues reads on the FIFO rd_en/rd_data/rd_empty port and
// re-presents the words as a valid/ready stream with a per-frame last marker.
// The FIFO's one-cycle read latency is hidden behind a 2-entry in-order output
// buffer. Reads are only issued when the word can be stored, so back-pressure
// never loses a word and a ready consumer sees one word per cycle.
//
// Ports
//   clk_i       read-domain clock (same as FIFO clk_rd_i)
//   rst_i       asynchronous active-high reset
//   enable_i    permits new FIFO reads; reads already issued still complete
//   rd_en_o     FIFO read request (combinational)
//   rd_data_i   FIFO read data, valid the cycle after an accepted read
//   rd_empty_i  FIFO empty flag
//   m_valid_o   output word valid
//   m_ready_i   consumer ready; a word is handed off when valid & ready
//   m_data_o    output word (head of buffer), zero while not valid
//   m_last_o    last word of the current frame, qualified by m_valid_o
//   words_o     count of words handed off, wraps modulo 2^CNT_WIDTH
//   busy_o      a read is pending or a word is buffered
// -----------------------------------------------------------------------------
module fifo_rd_stream #(
    parameter int DATA_WIDTH = 16,
    parameter int FRAME_LEN  = 8,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  enable_i,
    output logic                  rd_en_o,
    input  logic [DATA_WIDTH-1:0] rd_data_i,
    input  logic                  rd_empty_i,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic [DATA_WIDTH-1:0] m_data_o,
    output logic                  m_last_o,
    output logic [CNT_WIDTH-1:0]  words_o,
    output logic                  busy_o
);

    localparam int               IDX_W    = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    // Control state
    logic                  r_pend;       // read accepted last cycle, data on rd_data_i now
    logic [1:0]            r_occ;        // filled buffer entries, 0..2
    logic [IDX_W-1:0]      r_frame_idx;  // position of the head word within its frame
    logic [CNT_WIDTH-1:0]  r_words;

    // Output buffer storage (data only, never reset)
    logic [DATA_WIDTH-1:0] r_buf_head;
    logic [DATA_WIDTH-1:0] r_buf_tail;

    logic                  w_valid;
    logic                  w_pop;
    logic [2:0]            w_level;

    assign w_valid = (r_occ != 2'd0);
    assign w_pop   = w_valid & m_ready_i;

    // Slots that will still be committed after this edge. A new read is only
    // safe if its word has a free slot when it lands next cycle, which is what
    // keeps occ + pend <= 2. Subtracting pop lets a ready consumer keep the
    // FIFO streaming at full rate.
    assign w_level = {1'b0, r_occ} + {2'b00, r_pend} - {2'b00, w_pop};
    assign rd_en_o = ~rst_i & enable_i & ~rd_empty_i & (w_level < 3'd2);

    // ---- read issue -> capture/handoff boundary (control) ----
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_pend      <= 1'b0;
            r_occ       <= 2'd0;
            r_frame_idx <= '0;
            r_words     <= '0;
        end else begin
            r_pend <= rd_en_o;
            r_occ  <= r_occ + {1'b0, r_pend} - {1'b0, w_pop};
            if (w_pop) begin
                r_words <= r_words + CNT_WIDTH'(1);
                if (r_frame_idx == LAST_IDX) begin
                    r_frame_idx <= '0;
                end else begin
                    r_frame_idx <= r_frame_idx + IDX_W'(1);
                end
            end
        end
    end

    // ---- capture boundary (data) ----
    // Since occ + pend <= 2, a pop together with a capture only happens with
    // occ == 1, and a capture without a pop only with occ <= 1.
    always_ff @(posedge clk_i) begin
        if (w_pop) begin
            if (r_occ == 2'd2) begin
                r_buf_head <= r_buf_tail;
            end else if (r_pend) begin
                r_buf_head <= rd_data_i;
            end
        end else if (r_pend) begin
            if (r_occ == 2'd0) begin
                r_buf_head <= rd_data_i;
            end else begin
                r_buf_tail <= rd_data_i;
            end
        end
    end

    // Data is forced to zero while invalid so reset shows a clean bus without
    // resetting the storage registers.
    assign m_valid_o = w_valid;
    assign m_data_o  = w_valid ? r_buf_head : '0;
    assign m_last_o  = w_valid & (r_frame_idx == LAST_IDX);
    assign words_o   = r_words;
    assign busy_o    = r_pend | w_valid;

endmodule

// File: tb/tb_fifo_rd_stream.sv
module tb_fifo_rd_stream;

    localparam int DW = 16;
    localparam int FL = 8;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic          enable_i = 1'b0;
    logic          rd_en_o;
    logic [DW-1:0] rd_data_i = '0;
    logic          rd_empty_i = 1'b1;
    logic          m_valid_o;
    logic          m_ready_i = 1'b0;
    logic [DW-1:0] m_data_o;
    logic          m_last_o;
    logic [CW-1:0] words_o;
    logic          busy_o;

    fifo_rd_stream #(.DATA_WIDTH(DW), .FRAME_LEN(FL), .CNT_WIDTH(CW)) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .enable_i   (enable_i),
        .rd_en_o    (rd_en_o),
        .rd_data_i  (rd_data_i),
        .rd_empty_i (rd_empty_i),
        .m_valid_o  (m_valid_o),
        .m_ready_i  (m_ready_i),
        .m_data_o   (m_data_o),
        .m_last_o   (m_last_o),
        .words_o    (words_o),
        .busy_o     (busy_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // FIFO model contents and scoreboard of words read but not yet delivered
    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] last_q[$];

    // Reference model of the drain engine
    int            buf_m = 0;
    int            pend_m = 0;
    int            exp_idx = 0;
    logic [CW-1:0] exp_words = '0;
    bit            force_empty = 1'b0;
    bit            stall_prev = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic          prev_last = 1'b0;

    // Per-phase statistics
    int cyc = 0;
    int rden_cnt, deliv_cnt, first_rden_cyc, first_valid_cyc;
    int first_pop_cyc, last_pop_cyc, last_at;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        rden_cnt = 0; deliv_cnt = 0; first_rden_cyc = -1; first_valid_cyc = -1;
        first_pop_cyc = -1; last_pop_cyc = -1; last_at = 0;
        last_q.delete();
    endtask

    // One clock cycle, entered and left at the falling edge.
    task automatic cycle();
        logic          pop, exp_rden, acc;
        logic [DW-1:0] w, nd;
        nd = '0;
        rd_empty_i = force_empty || (fifo_q.size() == 0);
        #1;
        pop      = (buf_m != 0) && m_ready_i;
        exp_rden = enable_i && !rd_empty_i && ((buf_m + pend_m - (pop ? 1 : 0)) < 2);
        chk("rd_en", rd_en_o, exp_rden);
        chk("valid", m_valid_o, buf_m != 0);
        chk("last", m_last_o, (buf_m != 0) && (exp_idx == FL - 1));
        chk("busy", busy_o, (buf_m != 0) || (pend_m != 0));
        chk("words", words_o, exp_words);
        chk("occ_pend_le2", (int'(dut.r_occ) + int'(dut.r_pend)) <= 2, 1'b1);
        if (!enable_i) chk("rd_en_disabled", rd_en_o, 1'b0);
        if (stall_prev) begin
            chk("stall_data", m_data_o, prev_data);
            chk("stall_last", m_last_o, prev_last);
        end
        if (pop) begin
            chk("sb_depth", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
                w = exp_q.pop_front();
                chk("data", m_data_o, w);
            end
            deliv_cnt++;
            if (first_pop_cyc < 0) first_pop_cyc = cyc;
            last_pop_cyc = cyc;
            if (m_last_o) begin
                last_q.push_back(m_data_o);
                if (last_at == 0) last_at = deliv_cnt;
            end
        end
        if (m_valid_o && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (rd_en_o) begin
            rden_cnt++;
            if (first_rden_cyc < 0) first_rden_cyc = cyc;
        end
        // FIFO model: a read takes effect when requested and not empty
        acc = rd_en_o && !rd_empty_i;
        if (acc && fifo_q.size() != 0) begin
            nd = fifo_q.pop_front();
            exp_q.push_back(nd);
        end
        buf_m  = buf_m + pend_m - (pop ? 1 : 0);
        pend_m = acc ? 1 : 0;
        if (pop) begin
            exp_idx   = (exp_idx == FL - 1) ? 0 : exp_idx + 1;
            exp_words = exp_words + 1;
        end
        stall_prev = m_valid_o && !m_ready_i;
        prev_data  = m_data_o;
        prev_last  = m_last_o;
        cyc++;
        @(posedge clk);
        #1;
        rd_data_i = acc ? nd : DW'($urandom);
        @(negedge clk);
    endtask

    // Reset held across a rising edge; everything in flight is discarded.
    task automatic do_reset();
        rst_i = 1'b1;
        rd_empty_i = force_empty || (fifo_q.size() == 0);
        @(posedge clk);
        #1;
        chk("rst_rd_en", rd_en_o, 1'b0);
        chk("rst_valid", m_valid_o, 1'b0);
        chk("rst_data", m_data_o, '0);
        chk("rst_last", m_last_o, 1'b0);
        chk("rst_words", words_o, '0);
        chk("rst_busy", busy_o, 1'b0);
        exp_q.delete();
        buf_m = 0; pend_m = 0; exp_idx = 0; exp_words = '0; stall_prev = 1'b0;
        @(negedge clk);
        rst_i = 1'b0;
    endtask

    task automatic run_drain(input int max_cyc, input string tag);
        int n;
        n = 0;
        while ((fifo_q.size() != 0 || buf_m != 0 || pend_m != 0) && n < max_cyc) begin
            cycle();
            n++;
        end
        chk(tag, n < max_cyc, 1'b1);
    endtask

    initial begin
        int n;
        logic [DW-1:0] nv;

        // Reset and idle with an empty FIFO
        enable_i = 1'b1; m_ready_i = 1'b1;
        do_reset();
        clear_stats();
        repeat (20) cycle();
        chk("idle_rden_cnt", rden_cnt, 0);

        // Single word
        fifo_q.push_back(16'h0001);
        clear_stats();
        run_drain(20, "single_timeout");
        chk("single_rden_cnt", rden_cnt, 1);
        chk("single_latency", first_valid_cyc - first_rden_cyc, 2);
        chk("single_deliv", deliv_cnt, 1);
        chk("single_words", words_o, 1);
        chk("single_busy", busy_o, 1'b0);

        // Streaming 16 words, two frames of 8
        do_reset();
        for (int i = 1; i <= 16; i++) fifo_q.push_back(DW'(10 * i));
        clear_stats();
        run_drain(60, "stream_timeout");
        chk("stream_deliv", deliv_cnt, 16);
        chk("stream_span", last_pop_cyc - first_pop_cyc, 15);
        chk("stream_latency", first_pop_cyc - first_rden_cyc, 2);
        chk("stream_nlast", last_q.size(), 2);
        chk("stream_last0", (last_q.size() > 0) ? last_q[0] : 16'hFFFF, 80);
        chk("stream_last1", (last_q.size() > 1) ? last_q[1] : 16'hFFFF, 160);
        chk("stream_words", words_o, 16);

        // Back-pressure: 10 stalled cycles, then release
        do_reset();
        for (int i = 1; i <= 6; i++) fifo_q.push_back(DW'(16'h0030 + i));
        m_ready_i = 1'b0;
        clear_stats();
        repeat (10) cycle();
        chk("bp_rden_cnt", rden_cnt, 2);
        chk("bp_valid", m_valid_o, 1'b1);
        chk("bp_head", m_data_o, 16'h0031);
        m_ready_i = 1'b1;
        run_drain(40, "bp_timeout");
        chk("bp_deliv", deliv_cnt, 6);
        chk("bp_sb_empty", exp_q.size(), 0);
        chk("bp_words", words_o, 6);

        // Random enable / empty / ready gaps against the FIFO model
        do_reset();
        clear_stats();
        nv = 16'h0400;
        for (int i = 0; i < 1000; i++) begin
            enable_i    = ($urandom_range(0, 3) != 0);
            force_empty = ($urandom_range(0, 4) == 0);
            m_ready_i   = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 1) == 1) begin
                fifo_q.push_back(nv);
                nv = nv + 1;
            end
            cycle();
        end
        enable_i = 1'b1; force_empty = 1'b0; m_ready_i = 1'b1;
        run_drain(2000, "rand_timeout");
        chk("rand_deliv", deliv_cnt, int'(nv - 16'h0400));
        chk("rand_sb_empty", exp_q.size(), 0);

        // Reset mid-frame with two words buffered
        do_reset();
        for (int i = 0; i < 20; i++) fifo_q.push_back(DW'(16'h0200 + i));
        clear_stats();
        n = 0;
        while (deliv_cnt < 3 && n < 50) begin cycle(); n++; end
        chk("mid_pre_timeout", n < 50, 1'b1);
        m_ready_i = 1'b0;
        repeat (3) cycle();
        chk("mid_buffered_valid", m_valid_o, 1'b1);
        chk("mid_buffered_busy", busy_o, 1'b1);
        do_reset();
        m_ready_i = 1'b1;
        clear_stats();
        n = 0;
        while (deliv_cnt < 8 && n < 50) begin cycle(); n++; end
        chk("mid_post_timeout", n < 50, 1'b1);
        chk("mid_last_pos", last_at, 8);
        chk("mid_words", words_o, 8);
        run_drain(60, "mid_drain_timeout");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout required=completion");
        $fatal(1, "watchdog");
    end

endmodule
